// File: rtl/icg_pkg.sv
// Shared definitions for the clock-gating blocks: FSM state encoding and the
// gate-enable rule used by every gated channel.
package icg_pkg;

    localparam int ICG_ST_W = 2;

    // state     | meaning
    // ST_ACTIVE | clock running, writes accepted, idle timer counting
    // ST_GATED  | clock stopped, waiting for a write request
    // ST_WAKE   | one cycle reopening the clock before writes are accepted
    typedef enum logic [ICG_ST_W-1:0] {
        ST_ACTIVE = 2'd0,
        ST_GATED  = 2'd1,
        ST_WAKE   = 2'd2
    } icg_state_t;

    // Gate enable: the clock runs in every state except GATED, and always under test override.
    function automatic logic icg_cg_en(input icg_state_t st, input logic test_en);
        return (st != ST_GATED) | test_en;
    endfunction

endpackage

// File: rtl/icg_cell.sv
// Integrated clock gate: enable captured on the falling edge so it is stable
// for the whole high phase, then ANDed with the clock.
module icg_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic test_en,
    output logic gclk,
    output logic en_l
);

    // Capture the enable while the clock is low; reset leaves the clock running.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_l <= 1'b1;
        end else begin
            en_l <= en;
        end
    end

    // test_en only changes while the clock is low, so the OR cannot chop a high phase.
    assign gclk = clk & (en_l | test_en);

endmodule

// File: rtl/icg_regbank.sv
// Multi-channel register bank, one clock gate per channel. A channel stops its
// clock after IDLE_CYCLES cycles without a write and reopens it on demand.
//
// state     | meaning
// ST_ACTIVE | clock running, wr_ready = ch_en, idle timer counting no-write cycles
// ST_GATED  | clock stopped, wr_ready = 0, a write request starts the wake-up
// ST_WAKE   | gate reopens at this cycle's negedge, ACTIVE next cycle
module icg_regbank
    import icg_pkg::*;
#(
    parameter  int NUM_CH      = 2,
    parameter  int WIDTH       = 8,
    parameter  int IDLE_CYCLES = 4,
    localparam int CNT_W       = $clog2(IDLE_CYCLES + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic                    force_on,
    input  logic [NUM_CH-1:0]       wr_valid,
    input  logic [NUM_CH*WIDTH-1:0] wr_data,
    output logic [NUM_CH-1:0]       wr_ready,
    output logic [NUM_CH*WIDTH-1:0] q,
    output logic [NUM_CH-1:0]       gated
);

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        icg_state_t       state;
        logic [CNT_W-1:0] idle_cnt;
        logic             accept;
        logic             cg_en;
        logic             gclk;
        logic             en_l;
        logic [WIDTH-1:0] q_r;

        // Readiness depends only on state and permit so it is valid straight out of reset.
        assign wr_ready[i] = (state == ST_ACTIVE) & ch_en[i];
        assign accept      = wr_valid[i] & wr_ready[i];

        // Channel FSM and idle timer; dropping the permit overrides every other transition.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state    <= ST_ACTIVE;
                idle_cnt <= '0;
            end else if (!ch_en[i]) begin
                state    <= ST_GATED;
                idle_cnt <= '0;
            end else begin
                case (state)
                    ST_ACTIVE: begin
                        if (accept) begin
                            idle_cnt <= '0;
                        end else if (idle_cnt == IDLE_LAST) begin
                            state    <= ST_GATED;
                            idle_cnt <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + CNT_W'(1);
                        end
                    end
                    ST_GATED: begin
                        if (wr_valid[i]) begin
                            state <= ST_WAKE;
                        end
                    end
                    ST_WAKE: begin
                        state    <= ST_ACTIVE;
                        idle_cnt <= '0;
                    end
                    default: begin
                        state    <= ST_GATED;
                        idle_cnt <= '0;
                    end
                endcase
            end
        end

        assign cg_en = icg_cg_en(state, force_on);

        icg_cell u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (cg_en),
            .test_en (force_on),
            .gclk    (gclk),
            .en_l    (en_l)
        );

        // Channel register on the gated clock; the hold mux covers idle ACTIVE and forced cycles.
        always_ff @(posedge gclk or negedge rst_n) begin
            if (!rst_n) begin
                q_r <= '0;
            end else if (accept) begin
                q_r <= wr_data[i*WIDTH +: WIDTH];
            end
        end

        assign q[i*WIDTH +: WIDTH] = q_r;
        assign gated[i]            = ~en_l;
    end

endmodule

// File: tb/tb_icg_regbank.sv
// Bench for icg_regbank: directed scenarios followed by random traffic, all
// checked cycle by cycle against a behavioural model of each channel.
module tb_icg_regbank;

    localparam int NUM_CH      = 2;
    localparam int WIDTH       = 8;
    localparam int IDLE_CYCLES = 4;

    localparam int M_AWAKE  = 0;
    localparam int M_ASLEEP = 1;
    localparam int M_RISING = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  ch_en;
    logic        force_on;
    logic [1:0]  wr_valid;
    logic [15:0] wr_data;
    logic [1:0]  wr_ready;
    logic [15:0] q;
    logic [1:0]  gated;

    int n_chk  = 0;
    int n_fail = 0;

    int         m_mode  [2];
    int         m_quiet [2];
    logic [7:0] m_q     [2];

    logic g0, g1;
    int   g0_edges  = 0;
    int   g1_edges  = 0;
    int   glitches0 = 0;
    int   glitches1 = 0;

    icg_regbank #(
        .NUM_CH      (NUM_CH),
        .WIDTH       (WIDTH),
        .IDLE_CYCLES (IDLE_CYCLES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ch_en    (ch_en),
        .force_on (force_on),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .q        (q),
        .gated    (gated)
    );

    always #5 clk = ~clk;

    assign g0 = dut.g_ch[0].gclk;
    assign g1 = dut.g_ch[1].gclk;

    // Gated clock edges may only land on clk edges: rises at t%10==5, falls at t%10==0.
    always @(g0) begin
        if (g0 === 1'b1) begin
            g0_edges = g0_edges + 1;
            if ($time % 10 != 5) glitches0 = glitches0 + 1;
        end else if ($time % 10 != 0) begin
            glitches0 = glitches0 + 1;
        end
    end

    always @(g1) begin
        if (g1 === 1'b1) begin
            g1_edges = g1_edges + 1;
            if ($time % 10 != 5) glitches1 = glitches1 + 1;
        end else if ($time % 10 != 0) begin
            glitches1 = glitches1 + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_mode[c]  = M_AWAKE;
            m_quiet[c] = 0;
            m_q[c]     = 8'h00;
        end
    endtask

    // One rising clock edge of the channel rules, applied to the inputs as currently driven.
    task automatic model_step();
        for (int c = 0; c < 2; c++) begin
            bit took;
            took = (m_mode[c] == M_AWAKE) && ch_en[c] && wr_valid[c];
            if (took) m_q[c] = wr_data[c*8 +: 8];
            if (!ch_en[c]) begin
                m_mode[c]  = M_ASLEEP;
                m_quiet[c] = 0;
            end else if (m_mode[c] == M_AWAKE) begin
                m_quiet[c] = took ? 0 : m_quiet[c] + 1;
                if (m_quiet[c] == IDLE_CYCLES) begin
                    m_mode[c]  = M_ASLEEP;
                    m_quiet[c] = 0;
                end
            end else if (m_mode[c] == M_ASLEEP) begin
                if (wr_valid[c]) m_mode[c] = M_RISING;
            end else begin
                m_mode[c]  = M_AWAKE;
                m_quiet[c] = 0;
            end
        end
    endtask

    task automatic check_model();
        for (int c = 0; c < 2; c++) begin
            bit clk_on;
            clk_on = (m_mode[c] != M_ASLEEP) || force_on;
            chk($sformatf("q%0d", c), 32'(q[c*8 +: 8]), 32'(m_q[c]));
            chk($sformatf("wr_ready%0d", c), 32'(wr_ready[c]),
                32'((m_mode[c] == M_AWAKE) && ch_en[c]));
            chk($sformatf("gated%0d", c), 32'(gated[c]), 32'(!clk_on));
        end
    endtask

    // Inputs change only while clk is low; outputs are checked just after the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
        check_model();
    endtask

    initial begin
        int e0, e1;
        logic [15:0] q_snap;

        rst_n    = 1'b0;
        ch_en    = 2'b11;
        force_on = 1'b0;
        wr_valid = 2'b00;
        wr_data  = 16'h0000;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("reset_q", 32'(q), 'h0);
        chk("reset_wr_ready", 32'(wr_ready), 'h3);
        chk("reset_gated", 32'(gated), 'h0);
        rst_n = 1'b1;

        // Single write to ch0 lands one cycle later, ch1 untouched
        wr_valid = 2'b01;
        wr_data  = 16'h003C;
        cycle();
        chk("write_q0", 32'(q[7:0]), 'h3C);
        chk("write_q1", 32'(q[15:8]), 'h00);

        // Idle gating after IDLE_CYCLES quiet cycles
        wr_valid = 2'b00;
        repeat (IDLE_CYCLES - 1) cycle();
        chk("idle_not_yet_gated", 32'(gated[0]), 'h0);
        cycle();
        chk("idle_gated", 32'(gated[0]), 'h1);
        e0 = g0_edges;
        repeat (3) cycle();
        chk("gated_gclk0_quiet", 32'(g0_edges - e0), 'h0);

        // Wake from GATED with the request held
        wr_valid = 2'b01;
        wr_data  = 16'h005A;
        cycle();
        chk("wake_ready_low", 32'(wr_ready[0]), 'h0);
        chk("wake_gate_open", 32'(gated[0]), 'h0);
        cycle();
        chk("wake_ready_high", 32'(wr_ready[0]), 'h1);
        chk("wake_q0_not_yet", 32'(q[7:0]), 'h3C);
        cycle();
        chk("wake_q0", 32'(q[7:0]), 'h5A);

        // Reset in the middle of traffic with q0 = A5 and ch1 gated
        wr_data = 16'h00A5;
        cycle();
        chk("pre_reset_q0", 32'(q[7:0]), 'hA5);
        chk("pre_reset_gated", 32'(gated), 'h2);
        wr_valid = 2'b11;
        wr_data  = 16'hFFFF;
        rst_n    = 1'b0;
        #1;
        chk("async_reset_q", 32'(q), 'h0);
        chk("async_reset_wr_ready", 32'(wr_ready), 'h3);
        chk("async_reset_gated", 32'(gated), 'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_drops_write", 32'(q), 'h0);
        rst_n = 1'b1;

        // Permit removed during back-to-back writes on ch1
        wr_data = 16'h1122;
        cycle();
        wr_data = 16'h3344;
        cycle();
        chk("b2b_q1", 32'(q[15:8]), 'h33);
        ch_en   = 2'b01;
        wr_data = 16'h5566;
        cycle();
        chk("ch_en_off_ready", 32'(wr_ready[1]), 'h0);
        chk("ch_en_off_gated", 32'(gated[1]), 'h1);
        chk("ch_en_off_q1", 32'(q[15:8]), 'h33);
        wr_data = 16'h7788;
        repeat (2) cycle();
        chk("ch_en_off_q1_frozen", 32'(q[15:8]), 'h33);
        chk("ch_en_off_q0_live", 32'(q[7:0]), 'h88);
        ch_en   = 2'b11;
        wr_data = 16'h9ABC;
        cycle();
        chk("reenable_ready_low", 32'(wr_ready[1]), 'h0);
        cycle();
        chk("reenable_ready_high", 32'(wr_ready[1]), 'h1);
        cycle();
        chk("reenable_q1", 32'(q[15:8]), 'h9A);

        // Test override with both channels gated
        wr_valid = 2'b00;
        repeat (IDLE_CYCLES + 2) cycle();
        chk("both_gated", 32'(gated), 'h3);
        q_snap   = q;
        force_on = 1'b1;
        e0 = g0_edges;
        e1 = g1_edges;
        repeat (3) cycle();
        chk("force_gated", 32'(gated), 'h0);
        chk("force_gclk0_runs", 32'(g0_edges - e0 > 0), 'h1);
        chk("force_gclk1_runs", 32'(g1_edges - e1 > 0), 'h1);
        chk("force_q_hold", 32'(q), 32'(q_snap));
        force_on = 1'b0;
        cycle();
        chk("force_release_gated", 32'(gated), 'h3);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            ch_en[0]    = ($urandom_range(0, 9) != 0);
            ch_en[1]    = ($urandom_range(0, 9) != 0);
            wr_valid[0] = ($urandom_range(0, 3) == 0);
            wr_valid[1] = ($urandom_range(0, 3) == 0);
            force_on    = ($urandom_range(0, 19) == 0);
            wr_data     = 16'($urandom);
            cycle();
        end

        chk("gclk_glitch_free", 32'(glitches0 + glitches1), 'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
